sqrt_arbiter: RTL

SQRT_ARBITER -- requirements
Module: sqrt_arbiter

---
 rtl/sqrt_arbiter_if.sv | 28 ++
 rtl/sqrt_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/sqrt_arbiter_if.sv
// rtl/sqrt_arbiter_if.sv - requester and engine signal bundle for the shared sqrt arbiter
interface sqrt_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_num;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_res;
  logic                  rsp_err;
  logic                  busy;
  logic [WIDTH-1:0]      eng_num;
  logic                  eng_ready;
  logic                  eng_rst;
  logic                  eng_done;
  logic [WIDTH-1:0]      eng_res;

  modport slave (
    input  req, req_num, eng_done, eng_res,
    output gnt, rsp_valid, rsp_res, rsp_err, busy, eng_num, eng_ready, eng_rst
  );

  modport master (
    output req, req_num, eng_done, eng_res,
    input  gnt, rsp_valid, rsp_res, rsp_err, busy, eng_num, eng_ready, eng_rst
  );
endinterface

// File: rtl/sqrt_arbiter.sv
// rtl/sqrt_arbiter.sv - round-robin arbiter sharing one square-root engine among NREQ requesters
module sqrt_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 128
) (
  input  logic           clk,
  input  logic           reset,
  sqrt_arbiter_if.slave  bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    last_q, last_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             eng_rst_q, eng_rst_d;

  logic             found;
  logic [IW-1:0]    win;
  logic [IW-1:0]    cand;
  logic [NREQ-1:0]  sel;

  // Walk requesters starting just after the last one served; first hit wins.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_q) + k) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    num_d     = num_q;
    res_d     = res_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    eng_rst_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          idx_d   = win;
          num_d   = bus.req_num[int'(win)*WIDTH +: WIDTH];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.eng_done) begin
          res_d   = bus.eng_res;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          res_d     = '0;
          err_d     = 1'b1;
          eng_rst_d = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        last_d  = idx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      last_q    <= IW'(NREQ - 1);
      num_q     <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      eng_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      num_q     <= num_d;
      res_q     <= res_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      eng_rst_q <= eng_rst_d;
    end
  end

  // Every output is a decode of registered state, so nothing combinational reaches the ports.
  assign sel           = NREQ'(1) << idx_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.gnt       = (state_q != IDLE) ? sel : '0;
  assign bus.rsp_valid = (state_q == RESP) ? sel : '0;
  assign bus.rsp_res   = (state_q == RESP) ? res_q : '0;
  assign bus.rsp_err   = (state_q == RESP) & err_q;
  assign bus.eng_ready = (state_q == ISSUE);
  assign bus.eng_num   = num_q;
  assign bus.eng_rst   = eng_rst_q;
endmodule
